// File: rtl/demux8x32_buf.sv
// demux8x32_buf: 1-to-8 word distributor with a single-entry holding slot per destination.
// Optional broadcast to all slots is enabled by defining DEMUX8X32_BCAST_EN.
module demux8x32_buf #(
   parameter int WIDTH = 32,
   parameter int NCH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [2:0]           in_sel,
`ifdef DEMUX8X32_BCAST_EN
   input  logic                 in_bcast,
`endif
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic                 busy
);

   logic [NCH-1:0]   full_p1;
   logic [WIDTH-1:0] data_p1 [NCH];
   logic [NCH-1:0]   can_take;
   logic [NCH-1:0]   sel_dec;
   logic [NCH-1:0]   load;
   logic [NCH-1:0]   full_nxt;
   logic             accept;

   always_comb begin
      // A slot draining this cycle may be refilled in the same cycle.
      can_take = ~full_p1 | out_ready;
      sel_dec  = '0;
      sel_dec[in_sel] = 1'b1;
`ifdef DEMUX8X32_BCAST_EN
      in_ready = in_bcast ? (&can_take) : can_take[in_sel];
      accept   = in_valid & in_ready;
      load     = accept ? (in_bcast ? {NCH{1'b1}} : sel_dec) : '0;
`else
      in_ready = can_take[in_sel];
      accept   = in_valid & in_ready;
      load     = accept ? sel_dec : '0;
`endif
   end

   always_comb begin
      full_nxt = full_p1;
      for (int i = 0; i < NCH; i++) begin
         if (load[i])
            full_nxt[i] = 1'b1;
         else if (full_p1[i] && out_ready[i])
            full_nxt[i] = 1'b0;
      end
   end

   // Stage p1: slot state, presented one cycle after acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_p1 <= '0;
         busy    <= 1'b0;
         for (int i = 0; i < NCH; i++)
            data_p1[i] <= '0;
      end else begin
         full_p1 <= full_nxt;
         busy    <= |full_nxt;
         for (int i = 0; i < NCH; i++)
            if (load[i])
               data_p1[i] <= in_data;
      end
   end

   assign out_valid = full_p1;

   for (genvar g = 0; g < NCH; g++) begin : g_out
      assign out_data[WIDTH*g +: WIDTH] = data_p1[g];
   end

endmodule

// File: tb/tb_demux8x32_buf.sv
// Directed self-checking bench for demux8x32_buf (broadcast test when DEMUX8X32_BCAST_EN is defined).
module tb_demux8x32_buf;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  in_sel;
`ifdef DEMUX8X32_BCAST_EN
   logic        in_bcast;
`endif
   logic [7:0]   out_valid;
   logic [7:0]   out_ready;
   logic [255:0] out_data;
   logic         busy;

   int checks;
   int errors;

   demux8x32_buf #(.WIDTH(32), .NCH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
`ifdef DEMUX8X32_BCAST_EN
      .in_bcast  (in_bcast),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_data   = 32'h0;
      in_sel    = 3'd0;
      out_ready = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      step();
      checks++;
      if (out_valid !== 8'h00) begin
         errors++;
         $display("FAIL reset_out_valid: got %h expected %h", out_valid, 8'h00);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (out_data !== 256'h0) begin
         errors++;
         $display("FAIL reset_out_data: got %h expected 0", out_data);
      end
      for (int s = 0; s < 8; s++) begin
         in_sel = s[2:0];
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_sel%0d: got %b expected 1", s, in_ready);
         end
      end
      in_sel = 3'd0;
   endtask

   task automatic test_single();
      in_valid = 1'b1;
      in_sel   = 3'd3;
      in_data  = 32'hDEADBEEF;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_in_ready: got %b expected 1", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 8'h08) begin
         errors++;
         $display("FAIL single_out_valid: got %h expected 08", out_valid);
      end
      checks++;
      if (out_data[3*32 +: 32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_slice3: got %h expected deadbeef", out_data[3*32 +: 32]);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy: got %b expected 1", busy);
      end
      in_data = 32'h12345678;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_blocked_in_ready: got %b expected 0", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 8'h08 || out_data[3*32 +: 32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_blocked_hold: got valid %h slice %h expected 08 deadbeef",
                  out_valid, out_data[3*32 +: 32]);
      end
      in_valid  = 1'b0;
      out_ready = 8'h08;
      step();
      out_ready = 8'h00;
      checks++;
      if (out_valid !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got valid %h busy %b expected 00 0", out_valid, busy);
      end
      checks++;
      if (out_data[3*32 +: 32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_data_stable: got %h expected deadbeef", out_data[3*32 +: 32]);
      end
   endtask

   task automatic test_drain_fill();
      logic [31:0] deliv [4];
      int          ndeliv;
      ndeliv = 0;
      in_valid = 1'b1;
      in_sel   = 3'd5;
      in_data  = 32'h00000050;
      step();
      in_data   = 32'h00000055;
      out_ready = 8'h20;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL drainfill_in_ready: got %b expected 1", in_ready);
      end
      if (out_valid[5] && out_ready[5] && ndeliv < 4) begin
         deliv[ndeliv] = out_data[5*32 +: 32];
         ndeliv++;
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 8'h20 || out_data[5*32 +: 32] !== 32'h00000055) begin
         errors++;
         $display("FAIL drainfill_refill: got valid %h slice %h expected 20 00000055",
                  out_valid, out_data[5*32 +: 32]);
      end
      if (out_valid[5] && out_ready[5] && ndeliv < 4) begin
         deliv[ndeliv] = out_data[5*32 +: 32];
         ndeliv++;
      end
      step();
      out_ready = 8'h00;
      if (out_valid[5] && out_ready[5] && ndeliv < 4) begin
         deliv[ndeliv] = out_data[5*32 +: 32];
         ndeliv++;
      end
      checks++;
      if (ndeliv !== 2) begin
         errors++;
         $display("FAIL drainfill_count: got %0d expected 2", ndeliv);
      end else begin
         checks++;
         if (deliv[0] !== 32'h00000050 || deliv[1] !== 32'h00000055) begin
            errors++;
            $display("FAIL drainfill_order: got %h %h expected 00000050 00000055", deliv[0], deliv[1]);
         end
      end
      checks++;
      if (out_valid !== 8'h00) begin
         errors++;
         $display("FAIL drainfill_empty: got %h expected 00", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] sels [7];
      int         okcnt;
      sels = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      in_valid = 1'b1;
      in_sel   = 3'd2;
      in_data  = 32'h00000022;
      step();
      okcnt = 0;
      for (int k = 0; k < 7; k++) begin
         in_sel  = sels[k];
         in_data = 32'h10 + 32'(sels[k]);
         #1;
         if (in_ready === 1'b1) okcnt++;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (okcnt !== 7) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d expected 7", okcnt);
      end
      checks++;
      if (out_valid !== 8'hFF) begin
         errors++;
         $display("FAIL b2b_out_valid: got %h expected ff", out_valid);
      end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp;
         exp = (i == 2) ? 32'h00000022 : 32'h10 + 32'(i);
         checks++;
         if (out_data[i*32 +: 32] !== exp) begin
            errors++;
            $display("FAIL b2b_slice%0d: got %h expected %h", i, out_data[i*32 +: 32], exp);
         end
      end
      out_ready = 8'hFF;
      step();
      checks++;
      if (out_valid !== 8'h00) begin
         errors++;
         $display("FAIL b2b_drain_all: got %h expected 00", out_valid);
      end
      // same channel, consumer always ready
      out_ready = 8'h40;
      in_valid  = 1'b1;
      in_sel    = 3'd6;
      okcnt = 0;
      for (int k = 0; k < 3; k++) begin
         in_data = 32'hA0 + 32'(k);
         #1;
         if (in_ready === 1'b1) okcnt++;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (okcnt !== 3 || out_valid !== 8'h40 || out_data[6*32 +: 32] !== 32'h000000A2) begin
         errors++;
         $display("FAIL b2b_same_chan: got accepts %0d valid %h slice %h expected 3 40 000000a2",
                  okcnt, out_valid, out_data[6*32 +: 32]);
      end
      step();
      out_ready = 8'h00;
      checks++;
      if (out_valid !== 8'h00) begin
         errors++;
         $display("FAIL b2b_same_chan_drain: got %h expected 00", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      in_sel   = 3'd0;
      in_data  = 32'h0000AAAA;
      step();
      in_sel  = 3'd7;
      in_data = 32'h0000BBBB;
      step();
      checks++;
      if (out_valid !== 8'h81) begin
         errors++;
         $display("FAIL rstmid_prefill: got %h expected 81", out_valid);
      end
      rst     = 1'b1;
      in_sel  = 3'd4;
      in_data = 32'h00000044;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 8'h00 || busy !== 1'b0 || out_data !== 256'h0) begin
         errors++;
         $display("FAIL rstmid_clear: got valid %h busy %b data_nonzero %b expected 00 0 0",
                  out_valid, busy, (out_data != 256'h0));
      end
      step();
      checks++;
      if (out_valid !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_not_stored: got %h expected 00", out_valid);
      end
   endtask

   task automatic test_ready_ignored();
      out_ready = 8'hFF;
      step();
      step();
      out_ready = 8'h00;
      checks++;
      if (out_valid !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_ignored: got valid %h busy %b expected 00 0", out_valid, busy);
      end
   endtask

`ifdef DEMUX8X32_BCAST_EN
   task automatic test_bcast();
      in_bcast = 1'b0;
      in_valid = 1'b1;
      in_sel   = 3'd1;
      in_data  = 32'h00000011;
      step();
      in_bcast = 1'b1;
      in_sel   = 3'd4;
      in_data  = 32'hA5A5A5A5;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bcast_blocked: got %b expected 0", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 8'h02 || out_data[1*32 +: 32] !== 32'h00000011) begin
         errors++;
         $display("FAIL bcast_blocked_hold: got valid %h slice %h expected 02 00000011",
                  out_valid, out_data[1*32 +: 32]);
      end
      out_ready = 8'h02;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bcast_ready: got %b expected 1", in_ready);
      end
      step();
      in_valid  = 1'b0;
      in_bcast  = 1'b0;
      out_ready = 8'h00;
      checks++;
      if (out_valid !== 8'hFF || out_data !== {8{32'hA5A5A5A5}}) begin
         errors++;
         $display("FAIL bcast_all: got valid %h data %h expected ff all a5a5a5a5", out_valid, out_data);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      idle_inputs();
`ifdef DEMUX8X32_BCAST_EN
      in_bcast = 1'b0;
`endif
      test_reset();
      test_single();
      test_drain_fill();
      test_back_to_back();
      test_reset_mid();
      test_ready_ignored();
`ifdef DEMUX8X32_BCAST_EN
      test_bcast();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
